ingress_pkt_buffer: RTL and testbench



---
 rtl/switch_pkg.sv | 21 ++
 rtl/ingress_pkt_buffer_sync_fifo.sv | 51 +++++
 rtl/ingress_pkt_buffer.sv | 192 +++++++++++++++++++
 tb/tb_ingress_pkt_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch-wide constants and types for the ingress path.
package switch_pkg;

    localparam int N_PORTS    = 4;
    localparam int IDX_WIDTH  = 2;
    localparam int BEAT_WIDTH = 8;

    typedef logic [IDX_WIDTH-1:0] port_idx_t;

    typedef struct packed {
        logic                  last;
        logic [BEAT_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        WR_SOP  = 2'd0,
        WR_BODY = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/ingress_pkt_buffer_sync_fifo.sv
// Small first-word-fall-through FIFO; holds one destination per stored packet.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ingress_pkt_buffer.sv
// Store-and-forward packet buffer for one ingress port; whole packets are dropped on overflow.
// Optional drop counter output enabled by defining INGRESS_DROP_CNT_EN.
module ingress_pkt_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int N_PORTS    = switch_pkg::N_PORTS,
    parameter int IDX_WIDTH  = switch_pkg::IDX_WIDTH,
    parameter int ADDR_WIDTH = 6,
    parameter int DESC_AW    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [IDX_WIDTH-1:0]  out_dst,
    input  logic                  out_ready,
    output logic                  pkt_drop
`ifdef INGRESS_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    import switch_pkg::*;

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int DST_W  = $clog2(N_PORTS);
    localparam int MEM_W  = DATA_WIDTH + 1;

    // Each entry is {last, data}; read is combinational so the head falls through.
    logic [MEM_W-1:0]    mem_q [DEPTH];

    wr_state_t           state_q, state_d;
    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] wr_commit_q, wr_commit_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [DST_W-1:0]    cur_dst_q, cur_dst_d;
    logic                pkt_drop_q, pkt_drop_d;

    logic                data_full;
    logic                mem_we;
    logic                desc_push;
    logic [DST_W-1:0]    desc_din;
    logic                desc_pop;
    logic [DST_W-1:0]    desc_head;
    logic                desc_empty;
    logic                desc_full;
    logic [MEM_W-1:0]    head_beat;
    logic                rd_pop;

    // Full compares against the read pointer before this cycle's pop.
    always_comb begin
        data_full = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                    (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        cur_dst_d   = cur_dst_q;
        mem_we      = 1'b0;
        desc_push   = 1'b0;
        desc_din    = cur_dst_q;
        pkt_drop_d  = 1'b0;

        case (state_q)
            WR_SOP: begin
                if (in_valid) begin
                    if (!desc_full && !data_full) begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        cur_dst_d = in_data[DST_W-1:0];
                        if (in_last) begin
                            wr_commit_d = wr_ptr_q + 1'b1;
                            desc_push   = 1'b1;
                            desc_din    = in_data[DST_W-1:0];
                        end else begin
                            state_d = WR_BODY;
                        end
                    end else begin
                        pkt_drop_d = 1'b1;
                        if (!in_last) begin
                            state_d = WR_DROP;
                        end
                    end
                end
            end
            WR_BODY: begin
                if (in_valid) begin
                    if (!data_full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (in_last) begin
                            wr_commit_d = wr_ptr_q + 1'b1;
                            desc_push   = 1'b1;
                            state_d     = WR_SOP;
                        end
                    end else begin
                        // Throw away the partial packet by rewinding to the last commit.
                        wr_ptr_d   = wr_commit_q;
                        pkt_drop_d = 1'b1;
                        state_d    = in_last ? WR_SOP : WR_DROP;
                    end
                end
            end
            WR_DROP: begin
                if (in_valid && in_last) begin
                    state_d = WR_SOP;
                end
            end
            default: begin
                state_d = WR_SOP;
            end
        endcase
    end

    always_comb begin
        head_beat = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        out_valid = !desc_empty;
        out_data  = out_valid ? head_beat[DATA_WIDTH-1:0] : '0;
        out_last  = out_valid && head_beat[DATA_WIDTH];
        out_dst   = out_valid ? IDX_WIDTH'(desc_head) : '0;
        rd_pop    = out_valid && out_ready;
        rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_pop};
        desc_pop  = rd_pop && head_beat[DATA_WIDTH];
        pkt_drop  = pkt_drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WR_SOP;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            cur_dst_q   <= '0;
            pkt_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            cur_dst_q   <= cur_dst_d;
            pkt_drop_q  <= pkt_drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {in_last, in_data};
        end
    end

    sync_fifo #(
        .WIDTH (DST_W),
        .AW    (DESC_AW)
    ) u_desc_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (desc_push),
        .din   (desc_din),
        .pop   (desc_pop),
        .dout  (desc_head),
        .empty (desc_empty),
        .full  (desc_full)
    );

`ifdef INGRESS_DROP_CNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    // Counts alongside the decision so the total is current when pkt_drop is seen.
    always_comb begin
        drop_count_d = drop_count_q;
        if (pkt_drop_d && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        drop_count = drop_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_ingress_pkt_buffer.sv
// Directed plus random stimulus for ingress_pkt_buffer against a queue-based packet model.
module tb_ingress_pkt_buffer;
    import switch_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_dst;
    logic       out_ready = 1'b0;
    logic       pkt_drop;
`ifdef INGRESS_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    ingress_pkt_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_dst   (out_dst),
        .out_ready (out_ready),
        .pkt_drop  (pkt_drop)
`ifdef INGRESS_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        port_idx_t dst;
        beat_t     b;
    } exp_beat_t;

    // Model: committed beats awaiting delivery, the packet being received, and mode.
    exp_beat_t stored_q[$];
    beat_t     partial_q[$];
    port_idx_t m_dst;
    int        m_pkts;
    int        m_mode;         // 0 start of packet, 1 accepting body, 2 discarding
    bit        m_drop_prev;
    int        m_drop_total;

    int n_assert = 0;
    int n_fail   = 0;
    int obs_drops;
    int gen_rem  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        stored_q.delete();
        partial_q.delete();
        m_dst        = '0;
        m_pkts       = 0;
        m_mode       = 0;
        m_drop_prev  = 1'b0;
        m_drop_total = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r);
        int        used;
        bit        popping;
        bit        drop_now;
        bit        commit;
        beat_t     nb;
        exp_beat_t e;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        chk("out_valid", out_valid, m_pkts > 0);
        if (m_pkts > 0) begin
            chk("out_data", out_data, stored_q[0].b.data);
            chk("out_last", out_last, stored_q[0].b.last);
            chk("out_dst", out_dst, stored_q[0].dst);
        end
        chk("pkt_drop", pkt_drop, m_drop_prev);
        if (pkt_drop === 1'b1) obs_drops++;
`ifdef INGRESS_DROP_CNT_EN
        chk("drop_count", drop_count, (m_drop_total > 65535) ? 65535 : m_drop_total);
`endif
        $display("beat v=%0d d=%02h l=%0d rdy=%0d | out v=%0d d=%02h l=%0d dst=%0d drop=%0d",
                 v, d, l, r, out_valid, out_data, out_last, out_dst, pkt_drop);

        used     = stored_q.size() + partial_q.size();
        popping  = (m_pkts > 0) && r;
        drop_now = 1'b0;
        commit   = 1'b0;
        nb.last  = l;
        nb.data  = d;
        if (v) begin
            case (m_mode)
                0: begin
                    if (m_pkts < 8 && used < 64) begin
                        partial_q.delete();
                        partial_q.push_back(nb);
                        m_dst = d[1:0];
                        if (l) commit = 1'b1;
                        else   m_mode = 1;
                    end else begin
                        drop_now = 1'b1;
                        if (!l) m_mode = 2;
                    end
                end
                1: begin
                    if (used < 64) begin
                        partial_q.push_back(nb);
                        if (l) begin
                            commit = 1'b1;
                            m_mode = 0;
                        end
                    end else begin
                        partial_q.delete();
                        drop_now = 1'b1;
                        m_mode   = l ? 0 : 2;
                    end
                end
                default: begin
                    if (l) m_mode = 0;
                end
            endcase
        end
        m_drop_prev  = drop_now;
        m_drop_total = m_drop_total + int'(drop_now);
        if (popping) begin
            e = stored_q.pop_front();
            if (e.b.last) m_pkts--;
        end
        if (commit) begin
            foreach (partial_q[i]) begin
                e.dst = m_dst;
                e.b   = partial_q[i];
                stored_q.push_back(e);
            end
            partial_q.delete();
            m_pkts++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_dst", out_dst, 2'd0);
        chk("rst_pkt_drop", pkt_drop, 1'b0);
`ifdef INGRESS_DROP_CNT_EN
        chk("rst_drop_count", drop_count, 16'd0);
`endif
        $display("reset released");
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r);
    endtask

    // Random beat source: packets of 1..8 beats, with idle gaps.
    task automatic rand_cycle(input int valid_pct, input int ready_pct);
        bit         v;
        bit         r;
        logic [7:0] d;
        v = ($urandom_range(99) < valid_pct);
        r = ($urandom_range(99) < ready_pct);
        d = 8'($urandom);
        if (v && gen_rem == 0) gen_rem = $urandom_range(8, 1);
        if (v) begin
            step(1'b1, d, gen_rem == 1, r);
            gen_rem--;
        end else begin
            step(1'b0, d, 1'b0, r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        do_reset();

        // 3-beat packet with the reader always ready.
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Single-beat packet.
        step(1'b1, 8'h03, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Nine single-beat packets with no reader: the descriptor store takes eight.
        obs_drops = 0;
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
        idle(2, 1'b0);
        chk("nine_pkt_drops", obs_drops, 1);
        idle(12, 1'b1);

        // 70-beat packet overflows the 64-beat data store, then a 4-beat packet fits.
        obs_drops = 0;
        for (int i = 0; i < 70; i++) step(1'b1, 8'(i + 1), i == 69, 1'b0);
        idle(2, 1'b0);
        chk("long_pkt_drops", obs_drops, 1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h41 + i), i == 3, 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);

        // Reset in the middle of a packet, then a fresh 2-beat packet.
        step(1'b1, 8'h02, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Packet A stored, then B written while A drains with ready toggling.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), i == 5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h23 + i), i == 4, (i % 2) == 0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0, (i % 2) == 1);
        idle(4, 1'b1);

        // Random traffic: balanced, then congested, then drain.
        for (int i = 0; i < 400; i++) rand_cycle(75, 60);
        for (int i = 0; i < 300; i++) rand_cycle(90, 10);
        for (int i = 0; i < 200; i++) rand_cycle(60, 50);
        while (gen_rem != 0) begin
            step(1'b1, 8'($urandom), gen_rem == 1, 1'b1);
            gen_rem--;
        end
        idle(80, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
